// File: rtl/alu_status_reg_pkg.sv
// Shared constants for the adder status stage: flag bit positions,
// handshake state encoding and the default datapath width.
package alu_status_reg_pkg;

    localparam int ALU_WIDTH = 8;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_status_reg_flag_next.sv
// alu_flag_next: combinational next-NZCV from the adder outputs.
// In a chained op Z accumulates so a multi-byte result is zero only if
// every byte was zero.
module alu_flag_next
    import alu_status_reg_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] Sum,
    input  logic             Cout,
    input  logic             Ovr,
    input  logic             Use_carry,
    input  logic             z_old_i,
    output logic [3:0]       flags_nxt_o
);

    logic sum_zero;

    assign sum_zero = (Sum == '0);

    // Assemble next NZCV; Z is ANDed with the stored Z for chained ops
    always_comb begin
        flags_nxt_o         = 4'b0000;
        flags_nxt_o[FLAG_N] = Sum[WIDTH-1];
        flags_nxt_o[FLAG_Z] = Use_carry ? (z_old_i & sum_zero) : sum_zero;
        flags_nxt_o[FLAG_C] = Cout;
        flags_nxt_o[FLAG_V] = Ovr;
    end

endmodule

// File: rtl/alu_status_reg.sv
// alu_status_reg: one-entry result buffer with valid/ready handshake,
// NZCV status flags and carry-in generation for ADC/SBC chains.
// Optional build macro STICKY_OVR_EN adds the Ovr_sticky output.
module alu_status_reg
    import alu_status_reg_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] Sum,
    input  logic             Cout,
    input  logic             Ovr,
    input  logic             Cin_req,
    input  logic             Use_carry,
    output logic             Cin,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic             Flag_we,
    input  logic             Flag_load,
    input  logic [3:0]       Flag_din,
    output logic [WIDTH-1:0] Result,
    output logic             Result_valid,
    input  logic             Result_ready,
    output logic [3:0]       Flags
`ifdef STICKY_OVR_EN
    ,
    output logic             Ovr_sticky
`endif
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       flags_nxt;
    logic             accept;
    logic             flag_upd;

    // Pass-through: a full buffer still accepts when it is drained this cycle
    assign In_ready     = (state_q == ST_EMPTY) | Result_ready;
    assign accept       = In_valid & In_ready;
    assign flag_upd     = accept & Flag_we;
    assign Result_valid = (state_q == ST_FULL);
    assign Result       = result_q;
    assign Flags        = flags_q;
    assign Cin          = Use_carry ? flags_q[FLAG_C] : Cin_req;

    alu_flag_next #(.WIDTH(WIDTH)) u_flag_next (
        .Sum        (Sum),
        .Cout       (Cout),
        .Ovr        (Ovr),
        .Use_carry  (Use_carry),
        .z_old_i    (flags_q[FLAG_Z]),
        .flags_nxt_o(flags_nxt)
    );

    // Handshake next state and flag next value (load beats update)
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        if (accept)
            state_d = ST_FULL;
        else if ((state_q == ST_FULL) && Result_ready)
            state_d = ST_EMPTY;
        if (Flag_load)
            flags_d = Flag_din;
        else if (flag_upd)
            flags_d = flags_nxt;
    end

    // State, result buffer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_EMPTY;
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            if (accept)
                result_q <= Sum;
        end
    end

`ifdef STICKY_OVR_EN
    logic ovr_sticky_q;

    assign Ovr_sticky = ovr_sticky_q;

    // Sticky overflow: set by any flagged overflow, cleared only by a load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovr_sticky_q <= 1'b0;
        else if (Flag_load)
            ovr_sticky_q <= 1'b0;
        else if (flag_upd && Ovr)
            ovr_sticky_q <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_alu_status_reg.sv
// Directed bench for alu_status_reg. Inputs change 1 ns after the rising
// edge and outputs are checked at that point, away from the active edge.
// Build with STICKY_OVR_EN defined to also cover the Ovr_sticky output.
module tb_alu_status_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] Sum;
    logic       Cout, Ovr, Cin_req, Use_carry, Cin;
    logic       In_valid, In_ready, Flag_we, Flag_load;
    logic [3:0] Flag_din;
    logic [7:0] Result;
    logic       Result_valid, Result_ready;
    logic [3:0] Flags;
`ifdef STICKY_OVR_EN
    logic       Ovr_sticky;
`endif

    int checks = 0;
    int errors = 0;

    alu_status_reg #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Sum         (Sum),
        .Cout        (Cout),
        .Ovr         (Ovr),
        .Cin_req     (Cin_req),
        .Use_carry   (Use_carry),
        .Cin         (Cin),
        .In_valid    (In_valid),
        .In_ready    (In_ready),
        .Flag_we     (Flag_we),
        .Flag_load   (Flag_load),
        .Flag_din    (Flag_din),
        .Result      (Result),
        .Result_valid(Result_valid),
        .Result_ready(Result_ready),
        .Flags       (Flags)
`ifdef STICKY_OVR_EN
        ,
        .Ovr_sticky  (Ovr_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. reset with In_valid asserted
        rst_n = 1'b0; Sum = 8'h55; Cout = 1'b1; Ovr = 1'b1; Cin_req = 1'b0;
        Use_carry = 1'b0; In_valid = 1'b1; Flag_we = 1'b1; Flag_load = 1'b0;
        Flag_din = 4'b0000; Result_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", Result_valid, 1'b0);
        chk("rst_flags", Flags, 4'b0000);
        chk("rst_result", Result, 8'h00);
        In_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", In_ready, 1'b1);

        // 2. single op, N and V set
        Sum = 8'h80; Cout = 1'b0; Ovr = 1'b1; Flag_we = 1'b1; Result_ready = 1'b1;
        In_valid = 1'b1;
        #1;
        chk("add_cin", Cin, 1'b0);
        tick();
        chk("add_result", Result, 8'h80);
        chk("add_valid", Result_valid, 1'b1);
        chk("add_flags", Flags, 4'b1001);

        // 3. two-byte ADC, low byte zero with carry out
        Sum = 8'h00; Cout = 1'b1; Ovr = 1'b0; Use_carry = 1'b0;
        tick();
        chk("adc_lo_flags", Flags, 4'b0110);
        Cin_req = 1'b1;
        #1;
        chk("cin_req_path", Cin, 1'b1);
        Cin_req = 1'b0;
        Use_carry = 1'b1;
        #1;
        chk("adc_cin_from_c", Cin, 1'b1);
        Sum = 8'h00; Cout = 1'b0;
        tick();
        chk("adc_hi_zero", Flags, 4'b0100);
        // repeat with a nonzero high byte
        Use_carry = 1'b0; Sum = 8'h00; Cout = 1'b1;
        tick();
        Use_carry = 1'b1; Sum = 8'h01; Cout = 1'b0;
        tick();
        chk("adc_hi_nonzero", Flags, 4'b0000);
        chk("adc_hi_result", Result, 8'h01);

        // drain the buffer
        Use_carry = 1'b0; In_valid = 1'b0;
        tick();
        chk("drain_valid", Result_valid, 1'b0);

        // 4. backpressure
        Result_ready = 1'b0; In_valid = 1'b1; Sum = 8'h11; Flag_we = 1'b0; Cout = 1'b0;
        tick();
        chk("bp_accept", Result, 8'h11);
        Sum = 8'h22; Cout = 1'b1; Flag_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", In_ready, 1'b0);
            tick();
            chk("bp_hold_result", Result, 8'h11);
            chk("bp_hold_valid", Result_valid, 1'b1);
        end
        chk("bp_hold_flags", Flags, 4'b0000);
        Result_ready = 1'b1;
        #1;
        chk("bp_release_ready", In_ready, 1'b1);
        tick();
        chk("bp_pass_result", Result, 8'h22);
        chk("bp_pass_valid", Result_valid, 1'b1);
        chk("bp_pass_flags", Flags, 4'b0010);
        In_valid = 1'b0;
        tick();
        chk("bp_empty", Result_valid, 1'b0);

        // 5. Flag_load beats an accept update in the same cycle
        In_valid = 1'b1; Sum = 8'h33; Cout = 1'b1; Ovr = 1'b1; Flag_we = 1'b1;
        Flag_load = 1'b1; Flag_din = 4'b0110;
        tick();
        chk("load_flags", Flags, 4'b0110);
        chk("load_result", Result, 8'h33);
        Flag_load = 1'b0;

`ifdef STICKY_OVR_EN
        // 6. sticky overflow
        Sum = 8'h44; Cout = 1'b0; Ovr = 1'b1;
        tick();
        chk("sticky_set", Ovr_sticky, 1'b1);
        Ovr = 1'b0;
        tick();
        chk("sticky_v_follows", Flags, 4'b0000);
        chk("sticky_hold", Ovr_sticky, 1'b1);
        Flag_load = 1'b1; Flag_din = 4'b0001;
        tick();
        chk("sticky_clr", Ovr_sticky, 1'b0);
        chk("sticky_load_flags", Flags, 4'b0001);
        Flag_load = 1'b0;
`endif

        // reset in the middle of a held transaction
        Result_ready = 1'b0; In_valid = 1'b1; Sum = 8'h5A;
        tick();
        chk("mid_full", Result_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", Result_valid, 1'b0);
        chk("mid_rst_result", Result, 8'h00);
        chk("mid_rst_flags", Flags, 4'b0000);
        In_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready", In_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
